// File: rtl/pipelined_adder_pkg.sv
// adder_pkg: shared types and configuration helpers for the pipelined add/subtract unit.
package adder_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int stages_of(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic bit cfg_ok(input int width, input int chunk);
        return chunk > 0 && width >= chunk && width % chunk == 0;
    endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// adder_stage: resolves one CHUNK-bit slice and registers it with the carry, valid bit and operands.
// With PIPELINED_ADDER_OVF_EN defined it also registers the signed overflow of its top bit.
module adder_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  stage_ctl_t       ctl_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    output stage_ctl_t       ctl_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] s_o
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf_o
`endif
);
    localparam int LO = K * CHUNK;

    logic [CHUNK:0]   slice;
    logic [WIDTH-1:0] s_d, a_q, b_q, s_q;
    stage_ctl_t       ctl_d, ctl_q;

    assign slice = {1'b0, a_i[LO +: CHUNK]} + {1'b0, b_i[LO +: CHUNK]} + {{CHUNK{1'b0}}, ctl_i.carry};
    assign ctl_d = '{valid: ctl_i.valid, carry: slice[CHUNK]};

    always_comb begin
        s_d = s_i;
        s_d[LO +: CHUNK] = slice[CHUNK-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
        end else if (en_i) begin
            ctl_q <= ctl_d;
            a_q   <= a_i;
            b_q   <= b_i;
            s_q   <= s_d;
        end
    end

    assign ctl_o = ctl_q;
    assign a_o   = a_q;
    assign b_o   = b_q;
    assign s_o   = s_q;

`ifdef PIPELINED_ADDER_OVF_EN
    logic ovf_d, ovf_q;

    // carry into the slice MSB is recovered as a ^ b ^ sum at that bit
    assign ovf_d = a_i[LO+CHUNK-1] ^ b_i[LO+CHUNK-1] ^ slice[CHUNK-1] ^ slice[CHUNK];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (en_i)
            ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: valid/ready streaming add/subtract, one CHUNK-bit slice resolved per stage.
// Define PIPELINED_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int STAGES = stages_of(WIDTH, CHUNK);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
    end

    logic             advance;
    stage_ctl_t       ctl_p [STAGES+1];
    logic [WIDTH-1:0] a_p   [STAGES+1];
    logic [WIDTH-1:0] b_p   [STAGES+1];
    logic [WIDTH-1:0] s_p   [STAGES+1];

    // the whole pipe moves in lockstep, so a stall freezes every stage including bubbles
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // subtraction is a + ~b + ~borrow, folded in before the first slice
    assign ctl_p[0] = '{valid: in_valid, carry: c_in ^ sub};
    assign a_p[0]   = a;
    assign b_p[0]   = b ^ {WIDTH{sub}};
    assign s_p[0]   = '0;

`ifdef PIPELINED_ADDER_OVF_EN
    logic ovf_p [STAGES];
    assign ovf = ovf_p[STAGES-1];
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .K(k)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en_i  (advance),
            .ctl_i (ctl_p[k]),
            .a_i   (a_p[k]),
            .b_i   (b_p[k]),
            .s_i   (s_p[k]),
            .ctl_o (ctl_p[k+1]),
            .a_o   (a_p[k+1]),
            .b_o   (b_p[k+1]),
            .s_o   (s_p[k+1])
`ifdef PIPELINED_ADDER_OVF_EN
            ,
            .ovf_o (ovf_p[k])
`endif
        );
    end

    assign out_valid = ctl_p[STAGES].valid;
    assign c_out     = ctl_p[STAGES].carry;
    assign sum       = s_p[STAGES];

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed 8-bit cases plus randomized 32-bit streaming against an arithmetic reference.
module tb_pipelined_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       e_iv, e_ir, e_ci, e_sub, e_ov, e_or, e_co;
    logic [7:0] e_a, e_b, e_s;
    logic        w_iv, w_ir, w_ci, w_sub, w_ov, w_or, w_co;
    logic [31:0] w_a, w_b, w_s;
`ifdef PIPELINED_ADDER_OVF_EN
    logic e_ovf, w_ovf;
`endif

    pipelined_adder #(.WIDTH(8), .CHUNK(4)) u_e (
        .clk(clk), .rst(rst), .in_valid(e_iv), .in_ready(e_ir), .a(e_a), .b(e_b), .c_in(e_ci),
        .sub(e_sub), .out_valid(e_ov), .out_ready(e_or), .sum(e_s), .c_out(e_co)
`ifdef PIPELINED_ADDER_OVF_EN
        , .ovf(e_ovf)
`endif
    );

    pipelined_adder u_w (
        .clk(clk), .rst(rst), .in_valid(w_iv), .in_ready(w_ir), .a(w_a), .b(w_b), .c_in(w_ci),
        .sub(w_sub), .out_valid(w_ov), .out_ready(w_or), .sum(w_s), .c_out(w_co)
`ifdef PIPELINED_ADDER_OVF_EN
        , .ovf(w_ovf)
`endif
    );

    logic [33:0] q[$];
    logic [33:0] held;
    logic        hold = 1'b0;
    int cyc = 0, sent = 0, first_acc = -1, first_out = -1, run = 0, max_run = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // {ovf, c_out, sum} from signed/unsigned arithmetic on the operands
    function automatic logic [33:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
        logic [32:0] r;
        logic        o;
        longint      sr;
        if (sb) begin
            r[31:0] = a - b - 32'(ci);
            r[32]   = ({1'b0, a} >= ({1'b0, b} + 33'(ci)));
            sr      = longint'($signed(a)) - longint'($signed(b)) - longint'(ci);
        end else begin
            r  = {1'b0, a} + {1'b0, b} + 33'(ci);
            sr = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        end
`ifdef PIPELINED_ADDER_OVF_EN
        o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`else
        o = 1'b0;
        sr = 0;
`endif
        return {o, r};
    endfunction

    function automatic logic [33:0] cur32();
`ifdef PIPELINED_ADDER_OVF_EN
        return {w_ovf, w_co, w_s};
`else
        return {1'b0, w_co, w_s};
`endif
    endfunction

    task automatic rand32();
        w_a   = $urandom;
        w_b   = $urandom;
        w_ci  = 1'($urandom_range(0, 1));
        w_sub = 1'($urandom_range(0, 1));
    endtask

    // entered #1 after a rising edge with inputs set; observes at the falling edge
    task automatic cycle32();
        @(negedge clk);
        chk("in_ready", w_ir, !w_ov || w_or);
        if (hold) begin
            chk("hold_valid", w_ov, 1'b1);
            chk("hold_data", cur32(), held);
        end
        if (w_iv && w_ir) begin
            q.push_back(ref32(w_a, w_b, w_ci, w_sub));
            sent++;
            if (first_acc < 0) first_acc = cyc;
        end
        if (w_ov) begin
            if (first_out < 0) first_out = cyc;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (w_ov && w_or) begin
            if (q.size() == 0) chk("stale_beat", w_ov, 1'b0);
            else chk("result", cur32(), q.pop_front());
        end
        hold = w_ov && !w_or;
        held = cur32();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic dir8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic sb, input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        e_a = a; e_b = b; e_ci = ci; e_sub = sb; e_iv = 1'b1;
        @(posedge clk);
        #1;
        e_iv = 1'b0;
        lat  = 1;
        while (!e_ov && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd2);
        chk({tag, "_sum"}, e_s, es);
        chk({tag, "_cout"}, e_co, ec);
`ifdef PIPELINED_ADDER_OVF_EN
        chk({tag, "_ovf"}, e_ovf, eo);
`else
        if (eo) chk({tag, "_valid"}, e_ov, 1'b1);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        e_iv = 0; e_a = 0; e_b = 0; e_ci = 0; e_sub = 0; e_or = 1;
        w_iv = 0; w_a = 0; w_b = 0; w_ci = 0; w_sub = 0; w_or = 1;
        @(negedge clk);
        chk("rst_e_valid", e_ov, 1'b0);
        chk("rst_e_sum", e_s, 8'h00);
        chk("rst_e_cout", e_co, 1'b0);
        chk("rst_e_ready", e_ir, 1'b1);
        chk("rst_w_valid", w_ov, 1'b0);
        chk("rst_w_sum", w_s, 32'h0);
        chk("rst_w_cout", w_co, 1'b0);
        chk("rst_w_ready", w_ir, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        dir8("add_cin", 8'h3C, 8'h15, 1'b1, 1'b0, 8'h52, 1'b0, 1'b0);
        dir8("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        dir8("sub_borrow", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        dir8("sub_noborrow", 8'h20, 8'h10, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0);
        dir8("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

        first_acc = -1; first_out = -1; run = 0; max_run = 0;
        for (int i = 0; i < 16; i++) begin
            w_iv = 1'b1; w_or = 1'b1;
            rand32();
            cycle32();
        end
        w_iv = 1'b0;
        repeat (8) cycle32();
        chk("tput_latency", 64'(first_out - first_acc), 64'd4);
        chk("tput_run", 64'(max_run), 64'd16);
        chk("tput_drain", 64'(q.size()), 64'd0);

        sent = 0;
        n = 0;
        while ((sent < 100 || q.size() > 0) && n < 3000) begin
            w_iv = (sent < 100) && ($urandom_range(0, 3) != 0);
            rand32();
            w_or = 1'($urandom_range(0, 1));
            cycle32();
            n++;
        end
        chk("stream_sent", 64'(sent), 64'd100);
        chk("stream_drain", 64'(q.size()), 64'd0);

        w_or = 1'b0;
        w_iv = 1'b1;
        repeat (5) begin
            rand32();
            cycle32();
        end
        w_iv = 1'b0;
        chk("pre_rst_valid", w_ov, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_valid", w_ov, 1'b0);
        chk("midrst_ready", w_ir, 1'b1);
        chk("midrst_sum", w_s, 32'h0);
        q.delete();
        hold = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        w_or = 1'b1;
        repeat (10) cycle32();
        chk("post_rst_idle", w_ov, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined add/subtract unit; the successor to the 4-bit combinational adder. Operands are split into CHUNK-bit slices, with one slice resolved per pipeline stage and the carry registered between stages. A valid/ready handshake on both sides lets the unit sit between streaming producers and consumers. Supports add-with-carry and subtract-with-borrow.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK (elaboration error otherwise)
CHUNK, 8, bits resolved per stage; STAGES = WIDTH/CHUNK, at least 1

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: a+b+c_in; 1: a-b-c_in
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
c_out  output  1  add: carry-out; sub: 1 = no borrow, 0 = borrow

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset: all stage valid bits cleared; out_valid=0, sum=0, c_out=0. in_ready is 1 after reset.
- Global advance: advance = !out_valid || out_ready; in_ready = advance (combinational from out_ready and out_valid only, with no path from in_valid).
- Accept: a beat is taken when in_valid && in_ready.
- Stage entry: b is inverted and carry-in = ~c_in when sub=1; b is passed through and carry-in = c_in when sub=0. Inversion is applied at stage entry.
- Stage k (0..STAGES-1) computes slice k = a_k + b_k + carry_k. The result slice and carry are registered. Higher slices of a and b, and lower result slices, travel forward in delay registers.
- Latency: exactly STAGES cycles from accept to out_valid=1, given out_ready held high.
- Throughput: one beat per cycle when not stalled.
- Stall: when advance=0, every stage register holds, including valid bits. Bubbles are not compressed.
- Ordering: results are never reordered, dropped or duplicated.
- Output hold: out_valid, sum and c_out stay stable while out_valid && !out_ready.
- Empty stages: data registers of invalid stages may hold stale values. Only valid bits are reset-critical, except the output registers, which reset to 0.
- Reset mid-operation: all in-flight beats are discarded; out_valid drops asynchronously.
- STAGES=1: the block degenerates to a single registered adder with the same handshake.
- Wrap-around: sum wraps modulo 2^WIDTH; c_out reports the bit-WIDTH carry of the inverted-b addition.

Optional Feature:
Macro PIPELINED_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit), the two's-complement signed overflow of the operation. ovf = carry into MSB XOR carry out of MSB. It is registered with sum, has identical valid/hold semantics, and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package adder_pkg: function stages_of(WIDTH, CHUNK); localparam-style checks; a typedef for the per-stage control bundle (valid, carry).
- Sub-module adder_stage: one CHUNK-bit slice adder plus registers (result slice, carry, valid, operand pass-through), with enable=advance. It is instantiated STAGES times in a generate loop.

Test Plan:
- WIDTH=8, CHUNK=4: a=0x3C, b=0x15, c_in=1, sub=0 -> after 2 cycles sum=0x52, c_out=0.
- WIDTH=8, CHUNK=4: a=0xFF, b=0x01, c_in=0, sub=0 -> sum=0x00, c_out=1. With OVF_EN, a=0x7F, b=0x01 -> sum=0x80, ovf=1.
- WIDTH=8, CHUNK=4, subtract: a=0x10, b=0x20, c_in=0, sub=1 -> sum=0xF0, c_out=0. Also a=0x20, b=0x10, c_in=1 -> sum=0x0F, c_out=1.
- Default params, streaming: 100 random beats with out_ready randomly toggled -> every result matches the {c_out,sum} reference in order; outputs held stable during stalls; no beat accepted while in_ready=0.
- Back-to-back throughput: in_valid and out_ready held high for 16 beats -> out_valid high 16 consecutive cycles, starting STAGES cycles after the first accept.
- Reset mid-flight: assert rst with 3 beats in the pipe -> out_valid=0 immediately, and no stale beat emerges after reset release.
